// File: rtl/klp32_fetch_pkg.sv
// klp32_fetch_pkg: shared state encoding and constants for the instruction fetch controller
package klp32_fetch_pkg;
   typedef enum logic [1:0] {LOAD = 2'd0, FETCH = 2'd1, FAULT = 2'd2} state_t;
   localparam logic [1:0]  INST_ALIGN_MASK = 2'b11;
   localparam logic [31:0] NOP             = 32'h0000_0013;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: prefetch FIFO; flush wins over pop and may be combined with a push of the new head
module fetch_fifo #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 2
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       i_flush,
   input  logic                       i_push,
   input  logic [WIDTH-1:0]           i_din,
   input  logic                       i_pop,
   output logic [WIDTH-1:0]           o_dout,
   output logic [$clog2(DEPTH+1)-1:0] o_count
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PW-1:0]    r_rd, r_wr, w_wr_idx;
   logic [CW-1:0]    r_count;
   always_comb begin
      w_wr_idx = i_flush ? '0 : r_wr;
      o_dout   = r_mem[r_rd];
      o_count  = r_count;
   end
   always_ff @(posedge clk)
      if (i_push) r_mem[w_wr_idx] <= i_din;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         r_rd    <= '0;
         r_wr    <= '0;
         r_count <= '0;
      end else if (i_flush) begin
         r_rd    <= '0;
         r_wr    <= PW'(i_push);
         r_count <= CW'(i_push);
      end else begin
         r_rd    <= r_rd + PW'(i_pop);
         r_wr    <= r_wr + PW'(i_push);
         r_count <= r_count + CW'(i_push) - CW'(i_pop);
      end
endmodule

// File: rtl/inst_fetch_ctrl.sv
// inst_fetch_ctrl: shares a 4 KB instruction memory between the boot loader and the fetch path,
// prefetching {pc, inst} pairs to decode over valid/ready with branch redirect and misalignment fault.
module inst_fetch_ctrl
   import klp32_fetch_pkg::*;
#(
   parameter int              XLEN       = 32,
   parameter logic [XLEN-1:0] RESET_PC   = '0,
   parameter int              FIFO_DEPTH = 2,
   parameter bit              BOOT_LOAD  = 1'b1
) (
   input  logic            clk,
   input  logic            rst_n,
   output logic [XLEN-1:0] o_mem_addr,
   input  logic [XLEN-1:0] i_mem_inst,
   output logic            o_mem_we,
   output logic [XLEN-1:0] o_mem_wdata,
   input  logic            i_ld_valid,
   output logic            o_ld_ready,
   input  logic [XLEN-1:0] i_ld_addr,
   input  logic [XLEN-1:0] i_ld_data,
   input  logic            i_ld_done,
   input  logic            i_redirect_valid,
   input  logic [XLEN-1:0] i_redirect_pc,
   output logic            o_if_valid,
   input  logic            i_if_ready,
   output logic [XLEN-1:0] o_if_pc,
   output logic [XLEN-1:0] o_if_inst,
   output logic            o_fault
);
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   state_t            r_state;
   logic [XLEN-1:0]   r_pc, w_fetch_addr;
   logic [CW-1:0]     w_count;
   logic [2*XLEN-1:0] w_head;
   logic              w_load, w_fetch, w_misaligned, w_redir_ok, w_redir_bad, w_pop, w_push, w_flush;
   always_comb begin
      w_load       = r_state == LOAD;
      w_fetch      = r_state == FETCH;
      w_misaligned = |(i_redirect_pc[1:0] & INST_ALIGN_MASK);
      w_redir_ok   = w_fetch & i_redirect_valid & ~w_misaligned;
      w_redir_bad  = w_fetch & i_redirect_valid & w_misaligned;
      o_if_valid   = w_fetch & (w_count != '0) & ~i_redirect_valid;
      w_pop        = o_if_valid & i_if_ready;
      w_push       = w_redir_ok | (w_fetch & ~i_redirect_valid & ((w_count < CW'(FIFO_DEPTH)) | w_pop));
      w_flush      = w_redir_ok | w_redir_bad | (w_load & i_ld_done);
      w_fetch_addr = w_redir_ok ? i_redirect_pc : r_pc;
      o_mem_addr   = w_load ? i_ld_addr : w_fetch_addr;
      // rst_n gates the write so a loader beat caught by reset never lands in memory
      o_mem_we     = w_load & i_ld_valid & rst_n;
      o_mem_wdata  = i_ld_data;
      o_ld_ready   = w_load;
      o_if_pc      = w_head[2*XLEN-1:XLEN];
      o_if_inst    = o_if_valid ? w_head[XLEN-1:0] : XLEN'(NOP);
      o_fault      = r_state == FAULT;
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         r_state <= BOOT_LOAD ? LOAD : FETCH;
         r_pc    <= RESET_PC;
      end else if (w_load & i_ld_done) begin
         r_state <= FETCH;
         r_pc    <= RESET_PC;
      end else if (w_redir_bad)
         r_state <= FAULT;
      else if (w_redir_ok)
         r_pc <= i_redirect_pc + XLEN'(4);
      else if (w_push)
         r_pc <= r_pc + XLEN'(4);
   fetch_fifo #(.WIDTH(2*XLEN), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_flush (w_flush),
      .i_push  (w_push),
      .i_din   ({w_fetch_addr, i_mem_inst}),
      .i_pop   (w_pop),
      .o_dout  (w_head),
      .o_count (w_count)
   );
endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// tb_inst_fetch_ctrl: directed stimulus with a queue-based reference model checked every cycle
module tb_inst_fetch_ctrl;
   localparam int M_LOAD = 0, M_FETCH = 1, M_FAULT = 2;
   logic        clk = 0, rst_n = 0;
   logic [31:0] mem_addr, mem_inst, mem_wdata, ld_addr, ld_data, redirect_pc, if_pc, if_inst;
   logic        mem_we, ld_valid, ld_ready, ld_done, redirect_valid, if_valid, if_ready, fault;
   logic [31:0] envmem [1024];
   logic [31:0] mmem [1024];
   logic [63:0] q [$];
   int          ms;
   logic [31:0] mpc;
   int          checks = 0, errors = 0;

   always #5 clk = ~clk;

   inst_fetch_ctrl dut (
      .clk(clk), .rst_n(rst_n), .o_mem_addr(mem_addr), .i_mem_inst(mem_inst), .o_mem_we(mem_we),
      .o_mem_wdata(mem_wdata), .i_ld_valid(ld_valid), .o_ld_ready(ld_ready), .i_ld_addr(ld_addr),
      .i_ld_data(ld_data), .i_ld_done(ld_done), .i_redirect_valid(redirect_valid),
      .i_redirect_pc(redirect_pc), .o_if_valid(if_valid), .i_if_ready(if_ready), .o_if_pc(if_pc),
      .o_if_inst(if_inst), .o_fault(fault)
   );

   assign mem_inst = envmem[mem_addr[11:2]];

   initial begin
      for (int i = 0; i < 1024; i++) envmem[i] = 32'hA000_0000 | i;
      forever begin
         @(posedge clk);
         if (mem_we) envmem[mem_addr[11:2]] <= mem_wdata;
      end
   end

   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s at %0t: got %h expected %h", n, $time, a, e);
      end
   endtask

   initial begin
      bit pop, full;
      for (int i = 0; i < 1024; i++) mmem[i] = 32'hA000_0000 | i;
      ms = M_LOAD; mpc = 0;
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            ms = M_LOAD; mpc = 0; q.delete();
         end else if (ms == M_LOAD) begin
            if (ld_valid) mmem[ld_addr[11:2]] = ld_data;
            if (ld_done) begin ms = M_FETCH; mpc = 0; q.delete(); end
         end else if (ms == M_FETCH) begin
            if (redirect_valid && redirect_pc[1:0] != 2'b00) begin
               ms = M_FAULT; q.delete();
            end else if (redirect_valid) begin
               q.delete();
               q.push_back({redirect_pc, mmem[redirect_pc[11:2]]});
               mpc = redirect_pc + 32'd4;
            end else begin
               pop  = q.size() > 0 && if_ready;
               full = q.size() >= 2;
               if (pop) void'(q.pop_front());
               if (!full || pop) begin
                  q.push_back({mpc, mmem[mpc[11:2]]});
                  mpc = mpc + 32'd4;
               end
            end
         end
      end
   end

   initial forever begin
      bit ev;
      @(negedge clk);
      ev = ms == M_FETCH && q.size() > 0 && !redirect_valid;
      chk("if_valid", {31'b0, if_valid}, {31'b0, ev});
      if (ev) begin
         chk("if_pc", if_pc, q[0][63:32]);
         chk("if_inst", if_inst, q[0][31:0]);
      end
      chk("fault", {31'b0, fault}, {31'b0, ms == M_FAULT});
      chk("ld_ready", {31'b0, ld_ready}, {31'b0, ms == M_LOAD});
      chk("mem_we", {31'b0, mem_we}, {31'b0, rst_n && ms == M_LOAD && ld_valid});
      if (ms == M_LOAD) begin
         chk("mem_addr_ld", mem_addr, ld_addr);
         if (mem_we) chk("mem_wdata", mem_wdata, ld_data);
      end else
         chk("mem_addr", mem_addr,
             (ms == M_FETCH && redirect_valid && redirect_pc[1:0] == 2'b00) ? redirect_pc : mpc);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      ld_valid = 0; ld_addr = 0; ld_data = 0; ld_done = 0;
      redirect_valid = 0; redirect_pc = 0; if_ready = 0;
      repeat (2) step();
      rst_n = 1;
      #1 chk("rst_ld_ready", {31'b0, ld_ready}, 1);
      chk("rst_if_valid", {31'b0, if_valid}, 0);
      chk("rst_fault", {31'b0, fault}, 0);
      // boot load of two words
      ld_valid = 1; ld_addr = 0; ld_data = 32'h0050_0093;
      #1 chk("boot_we0", {31'b0, mem_we}, 1);
      step(); ld_addr = 4; ld_data = 32'h0010_8113;
      #1 chk("boot_we1", {31'b0, mem_we}, 1);
      step(); ld_valid = 0; ld_done = 1; if_ready = 1;
      #1 chk("boot_we_off", {31'b0, mem_we}, 0);
      step(); ld_done = 0;
      #1 chk("first_fetch_idle", {31'b0, if_valid}, 0);
      chk("first_fetch_addr", mem_addr, 0);
      step(); #1 chk("boot_pc0", if_pc, 0);
      chk("boot_inst0", if_inst, 32'h0050_0093);
      step(); #1 chk("boot_pc1", if_pc, 4);
      chk("boot_inst1", if_inst, 32'h0010_8113);
      // back-pressure from a fresh FETCH entry
      step(); rst_n = 0; #1 rst_n = 1; ld_done = 1; if_ready = 0;
      step(); ld_done = 0;
      repeat (4) step();
      #1 chk("bp_pc_hold", mem_addr, 8);
      chk("bp_if_pc", if_pc, 0);
      step(); if_ready = 1;
      #1 chk("bp_rel0", if_pc, 0);
      step(); #1 chk("bp_rel1", if_pc, 4);
      step(); #1 chk("bp_rel2", if_pc, 8);
      // aligned redirect with full FIFO
      step(); redirect_valid = 1; redirect_pc = 32'h40;
      #1 chk("redir_void", {31'b0, if_valid}, 0);
      chk("redir_addr", mem_addr, 32'h40);
      step(); redirect_valid = 0;
      #1 chk("redir_pc0", if_pc, 32'h40);
      step(); #1 chk("redir_pc1", if_pc, 32'h44);
      // loader isolation, then wrap past 4 KB
      step(); ld_valid = 1; ld_addr = 0; ld_data = 32'hDEAD_BEEF;
      #1 chk("iso_ready", {31'b0, ld_ready}, 0);
      chk("iso_we", {31'b0, mem_we}, 0);
      step(); ld_valid = 0; redirect_valid = 1; redirect_pc = 32'hFFC;
      step(); redirect_valid = 0;
      #1 chk("wrap_pc", if_pc, 32'hFFC);
      chk("wrap_inst", if_inst, 32'hA000_03FF);
      chk("wrap_addr", mem_addr, 32'h1000);
      step(); #1 chk("wrap_pc2", if_pc, 32'h1000);
      chk("wrap_inst2", if_inst, 32'h0050_0093);
      // misaligned redirect
      step(); redirect_valid = 1; redirect_pc = 32'h42;
      step(); redirect_valid = 0;
      #1 chk("mis_fault", {31'b0, fault}, 1);
      repeat (3) step();
      #1 chk("mis_valid", {31'b0, if_valid}, 0);
      chk("mis_fault_hold", {31'b0, fault}, 1);
      // asynchronous resets mid-operation
      rst_n = 0;
      #1 chk("arst_fault", {31'b0, fault}, 0);
      step(); rst_n = 1; ld_valid = 1; ld_addr = 8; ld_data = 32'h1234_5678;
      #1 chk("arst_we_pre", {31'b0, mem_we}, 1);
      rst_n = 0;
      #1 chk("arst_we", {31'b0, mem_we}, 0);
      step(); rst_n = 1; ld_valid = 0; ld_done = 1; if_ready = 0;
      step(); ld_done = 0;
      repeat (3) step();
      #1 chk("arst_full_valid", {31'b0, if_valid}, 1);
      rst_n = 0;
      #1 chk("arst_valid", {31'b0, if_valid}, 0);
      chk("arst_state", {31'b0, ld_ready}, 1);
      step(); rst_n = 1; ld_done = 1; if_ready = 1;
      step(); ld_done = 0; redirect_valid = 1; redirect_pc = 8;
      step(); redirect_valid = 0;
      #1 chk("arst_dropped", if_inst, 32'hA000_0002);
      repeat (3) step();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
